aes192_key_expand_rom_reader: RTL and testbench

//  AES-192 key-schedule engine: the read-side master of the Rcon ROM and S-box ROM
//  (1R ports: address0/ce0/q0, 1-cycle registered read latency). On start it expands
//  a 192-bit cipher key into round-key words w[0..51], streamed one word per valid

---
 rtl/aes192_key_expand_rom_reader.sv | 166 ++++++++++++++++
 tb/tb_aes192_key_expand_rom_reader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes192_key_expand_rom_reader.sv
// AES-192 key-schedule engine: drives the Rcon and S-box ROM read ports and
// streams round-key words w[0..51] one per rk_valid pulse.
module aes192_key_expand_rom_reader #(
  parameter int NUM_WORDS = 52,
  parameter int NK        = 6,
  parameter int RCON_AW   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [191:0]       key_in,
  output logic [RCON_AW-1:0] rcon_address0,
  output logic               rcon_ce0,
  input  logic [7:0]         rcon_q0,
  output logic [7:0]         sbox_address0,
  output logic               sbox_ce0,
  input  logic [7:0]         sbox_q0,
  output logic               rk_valid,
  output logic [5:0]         rk_index,
  output logic [31:0]        rk_word,
  output logic               busy,
  output logic               done
);

  localparam logic [5:0] LAST_IDX   = 6'(NUM_WORDS);
  localparam logic [5:0] KEY_WORDS  = 6'(NK);
  localparam logic [2:0] LAST_PHASE = 3'(NK - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_SUB, S_EMIT, S_DONE} state_t;

  state_t             r_state;
  logic [31:0]        r_win [NK];
  logic [5:0]         r_next;
  logic [2:0]         r_phase;
  logic [2:0]         r_sub;
  logic [RCON_AW-1:0] r_rcon_addr;
  logic [7:0]         r_rcon;
  logic [23:0]        r_temp;
  logic [31:0]        w_calc;
  logic [31:0]        w_subw;

  // The lowest S-box byte arrives in the emit decision cycle, so it is used straight off the ROM.
  function automatic logic [31:0] f_sched_mix(input logic [31:0] prev6,
                                              input logic [23:0] sub_hi,
                                              input logic [7:0]  sub_lo,
                                              input logic [7:0]  rcon);
    return prev6 ^ ({sub_hi, sub_lo} ^ {rcon, 24'h0});
  endfunction

  assign w_calc = r_win[0] ^ r_win[NK-1];
  assign w_subw = f_sched_mix(r_win[0], r_temp, sbox_q0, r_rcon);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_next        <= '0;
      r_phase       <= '0;
      r_sub         <= '0;
      r_rcon_addr   <= '0;
      rk_valid      <= 1'b0;
      rk_index      <= '0;
      rk_word       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rcon_address0 <= '0;
      rcon_ce0      <= 1'b0;
      sbox_address0 <= '0;
      sbox_ce0      <= 1'b0;
    end else begin
      rk_valid      <= 1'b0;
      done          <= 1'b0;
      rcon_ce0      <= 1'b0;
      sbox_ce0      <= 1'b0;
      rcon_address0 <= '0;
      sbox_address0 <= '0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int k = 0; k < NK; k++) r_win[k] <= key_in[191-32*k -: 32];
            rk_valid    <= 1'b1;
            rk_index    <= '0;
            rk_word     <= key_in[191:160];
            r_next      <= 6'd1;
            r_phase     <= 3'd1;
            r_rcon_addr <= '0;
            busy        <= 1'b1;
            r_state     <= S_LOAD;
          end
        end
        S_LOAD, S_CALC, S_EMIT: begin
          if (r_next == LAST_IDX) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end else if (r_next < KEY_WORDS) begin
            rk_valid <= 1'b1;
            rk_index <= r_next;
            rk_word  <= r_win[r_next[2:0]];
            r_next   <= r_next + 6'd1;
            r_phase  <= (r_phase == LAST_PHASE) ? 3'd0 : r_phase + 3'd1;
            r_state  <= S_LOAD;
          end else if (r_phase == 3'd0) begin
            // RotWord is folded into the issue order: a1, a2, a3, a0.
            sbox_address0 <= r_win[NK-1][23:16];
            sbox_ce0      <= 1'b1;
            rcon_address0 <= r_rcon_addr;
            rcon_ce0      <= 1'b1;
            r_sub         <= 3'd0;
            r_state       <= S_SUB;
          end else begin
            rk_valid <= 1'b1;
            rk_index <= r_next;
            rk_word  <= w_calc;
            for (int k = 0; k < NK-1; k++) r_win[k] <= r_win[k+1];
            r_win[NK-1] <= w_calc;
            r_next   <= r_next + 6'd1;
            r_phase  <= (r_phase == LAST_PHASE) ? 3'd0 : r_phase + 3'd1;
            r_state  <= S_CALC;
          end
        end
        S_SUB: begin
          case (r_sub)
            3'd0: begin
              sbox_address0 <= r_win[NK-1][15:8];
              sbox_ce0      <= 1'b1;
              r_sub         <= 3'd1;
            end
            3'd1: begin
              r_temp[23:16] <= sbox_q0;
              r_rcon        <= rcon_q0;
              sbox_address0 <= r_win[NK-1][7:0];
              sbox_ce0      <= 1'b1;
              r_sub         <= 3'd2;
            end
            3'd2: begin
              r_temp[15:8]  <= sbox_q0;
              sbox_address0 <= r_win[NK-1][31:24];
              sbox_ce0      <= 1'b1;
              r_sub         <= 3'd3;
            end
            3'd3: begin
              r_temp[7:0] <= sbox_q0;
              r_sub       <= 3'd4;
            end
            3'd4: begin
              rk_valid <= 1'b1;
              rk_index <= r_next;
              rk_word  <= w_subw;
              for (int k = 0; k < NK-1; k++) r_win[k] <= r_win[k+1];
              r_win[NK-1] <= w_subw;
              r_next      <= r_next + 6'd1;
              r_phase     <= 3'd1;
              r_rcon_addr <= r_rcon_addr + 1'b1;
              r_sub       <= 3'd0;
              r_state     <= S_EMIT;
            end
            default: r_sub <= 3'd0;
          endcase
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes192_key_expand_rom_reader.sv
// Directed bench for aes192_key_expand_rom_reader: ROM models, a reference key
// expansion and per-scenario checks of stream contents, timing and ROM traffic.
module tb_aes192_key_expand_rom_reader;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [191:0] key_in;
  logic [3:0]   rcon_address0;
  logic         rcon_ce0;
  logic [7:0]   rcon_q0;
  logic [7:0]   sbox_address0;
  logic         sbox_ce0;
  logic [7:0]   sbox_q0;
  logic         rk_valid;
  logic [5:0]   rk_index;
  logic [31:0]  rk_word;
  logic         busy, done;

  always #5 clk = ~clk;

  aes192_key_expand_rom_reader dut (
    .clk(clk), .reset(reset), .start(start), .key_in(key_in),
    .rcon_address0(rcon_address0), .rcon_ce0(rcon_ce0), .rcon_q0(rcon_q0),
    .sbox_address0(sbox_address0), .sbox_ce0(sbox_ce0), .sbox_q0(sbox_q0),
    .rk_valid(rk_valid), .rk_index(rk_index), .rk_word(rk_word),
    .busy(busy), .done(done)
  );

  localparam logic [2047:0] SBOX_P = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [191:0] KEY_A2  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [191:0] KEY_C2  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [191:0] KEY_ALT = 192'hdeadbeef0123456789abcdeffedcba9876543210a5a5a5a5;

  function automatic logic [7:0] f_sbox(input logic [7:0] a);
    return SBOX_P[(255 - int'(a))*8 +: 8];
  endfunction

  function automatic logic [7:0] f_rcon(input logic [3:0] a);
    case (a)
      4'd0: return 8'h01;  4'd1: return 8'h02;  4'd2: return 8'h04;  4'd3: return 8'h08;
      4'd4: return 8'h10;  4'd5: return 8'h20;  4'd6: return 8'h40;  4'd7: return 8'h80;
      4'd8: return 8'h1b;  4'd9: return 8'h36;  default: return 8'h00;
    endcase
  endfunction

  // ROMs: one-cycle registered read; junk on the port whenever ce0 was low.
  always @(posedge clk) begin
    if (sbox_ce0) sbox_q0 <= f_sbox(sbox_address0); else sbox_q0 <= 8'($urandom);
    if (rcon_ce0) rcon_q0 <= f_rcon(rcon_address0); else rcon_q0 <= 8'($urandom);
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_w [52];

  task automatic build_model(input logic [191:0] k);
    logic [31:0] t;
    for (int i = 0; i < 52; i++) begin
      if (i < 6) exp_w[i] = k[191-32*i -: 32];
      else begin
        t = exp_w[i-1];
        if (i % 6 == 0) begin
          t = {t[23:0], t[31:24]};
          t = {f_sbox(t[31:24]), f_sbox(t[23:16]), f_sbox(t[15:8]), f_sbox(t[7:0])}
              ^ {f_rcon(4'(i/6 - 1)), 24'h0};
        end
        exp_w[i] = exp_w[i-6] ^ t;
      end
    end
  endtask

  function automatic int f_cyc(input int i);
    if (i < 6) return 1 + i;
    return 12 + 11*((i-6)/6) + (i-6)%6;
  endfunction

  function automatic logic [54:0] f_outs();
    return {rk_valid, rk_index, rk_word, busy, done, rcon_address0, rcon_ce0, sbox_address0, sbox_ce0};
  endfunction

  int          q_idx[$];
  logic [31:0] q_word[$];
  int          q_cyc[$];
  int          rc_addr[$];
  int          rc_cyc[$];
  logic [7:0]  sb_addr[$];
  int          sb_cyc[$];
  int          done_cyc, done_cnt, viol;
  logic        busy_tr [0:127];
  logic [54:0] snap;

  // Start a run with key k (accept edge closes cycle T), then record ncyc cycles.
  task automatic run_stream(input logic [191:0] k, input int inj_at, input logic [191:0] k2,
                            input int rst_at, input int ncyc);
    q_idx.delete(); q_word.delete(); q_cyc.delete();
    rc_addr.delete(); rc_cyc.delete(); sb_addr.delete(); sb_cyc.delete();
    done_cyc = -1; done_cnt = 0; viol = 0; snap = '1;
    for (int n = 0; n < 128; n++) busy_tr[n] = 1'b0;
    @(negedge clk);
    key_in = k; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; key_in = ~k;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (rk_valid) begin q_idx.push_back(int'(rk_index)); q_word.push_back(rk_word); q_cyc.push_back(n); end
      if (rk_valid && !busy) viol++;
      if (done) begin if (done_cyc < 0) done_cyc = n; done_cnt++; end
      if (rcon_ce0) begin rc_addr.push_back(int'(rcon_address0)); rc_cyc.push_back(n); end
      if (sbox_ce0) begin sb_addr.push_back(sbox_address0); sb_cyc.push_back(n); end
      if (n < 128) busy_tr[n] = busy;
      if (rst_at > 0 && n == rst_at + 1) snap = f_outs();
      reset = 1'b0; start = 1'b0;
      if (n == inj_at) begin start = 1'b1; key_in = k2; end
      if (n == rst_at) reset = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; key_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (f_outs() !== 55'h0) begin n_fail++; $display("FAIL reset_outputs got=%h want=0", f_outs()); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({rk_valid, busy, done} !== 3'b000) begin n_fail++; $display("FAIL reset_idle got=%b want=000", {rk_valid, busy, done}); end
  endtask

  task automatic test_fips_stream();
    int bad;
    build_model(KEY_A2);
    run_stream(KEY_A2, 0, '0, 0, 100);
    n_checks++;
    if (q_idx.size() != 52) begin n_fail++; $display("FAIL fips_count got=%0d want=52", q_idx.size()); end
    for (int j = 0; j < q_idx.size() && j < 52; j++) begin
      n_checks++;
      if (q_idx[j] !== j || q_word[j] !== exp_w[j] || q_cyc[j] !== f_cyc(j)) begin
        n_fail++;
        $display("FAIL fips_word[%0d] got idx=%0d w=%h cyc=%0d want idx=%0d w=%h cyc=%0d",
                 j, q_idx[j], q_word[j], q_cyc[j], j, exp_w[j], f_cyc(j));
      end
    end
    if (q_idx.size() == 52) begin
      n_checks++;
      if (q_word[6] !== 32'hfe0c91f7 || q_cyc[6] !== 12) begin n_fail++; $display("FAIL fips_w6 got=%h@%0d want=fe0c91f7@12", q_word[6], q_cyc[6]); end
      n_checks++;
      if (q_word[7] !== 32'h2402f5a5) begin n_fail++; $display("FAIL fips_w7 got=%h want=2402f5a5", q_word[7]); end
      n_checks++;
      if (q_word[51] !== 32'h01002202 || q_cyc[51] !== 92) begin n_fail++; $display("FAIL fips_w51 got=%h@%0d want=01002202@92", q_word[51], q_cyc[51]); end
    end
    n_checks++;
    if (done_cyc !== 93 || done_cnt !== 1) begin n_fail++; $display("FAIL fips_done got cyc=%0d cnt=%0d want cyc=93 cnt=1", done_cyc, done_cnt); end
    bad = 0;
    for (int n = 1; n <= 100; n++) if (busy_tr[n] !== (n <= 92)) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL fips_busy got %0d wrong cycles want 0", bad); end
    n_checks++;
    if (viol != 0) begin n_fail++; $display("FAIL fips_valid_not_busy got=%0d want=0", viol); end
  endtask

  task automatic test_rom_addresses();
    logic [31:0] src;
    logic [7:0]  want;
    n_checks++;
    if (rc_addr.size() != 8) begin n_fail++; $display("FAIL rcon_count got=%0d want=8", rc_addr.size()); end
    for (int j = 0; j < rc_addr.size() && j < 8; j++) begin
      n_checks++;
      if (rc_addr[j] !== j || rc_cyc[j] !== 7 + 11*j) begin
        n_fail++; $display("FAIL rcon_addr[%0d] got=%0d@%0d want=%0d@%0d", j, rc_addr[j], rc_cyc[j], j, 7 + 11*j);
      end
    end
    n_checks++;
    if (sb_addr.size() != 32) begin n_fail++; $display("FAIL sbox_count got=%0d want=32", sb_addr.size()); end
    if (sb_addr.size() >= 4) begin
      n_checks++;
      if ({sb_addr[0], sb_addr[1], sb_addr[2], sb_addr[3]} !== 32'h2c6b7b52) begin
        n_fail++; $display("FAIL sbox_w6_order got=%h%h%h%h want=2c6b7b52", sb_addr[0], sb_addr[1], sb_addr[2], sb_addr[3]);
      end
    end
    for (int j = 0; j < sb_addr.size() && j < 32; j++) begin
      src  = exp_w[6*(j/4) + 5];
      want = src[31 - 8*((j % 4 + 1) % 4) -: 8];
      n_checks++;
      if (sb_addr[j] !== want || sb_cyc[j] !== 7 + 11*(j/4) + j%4) begin
        n_fail++; $display("FAIL sbox_addr[%0d] got=%h@%0d want=%h@%0d", j, sb_addr[j], sb_cyc[j], want, 7 + 11*(j/4) + j%4);
      end
    end
  endtask

  task automatic test_zero_key();
    int bad;
    build_model('0);
    run_stream('0, 0, '0, 0, 100);
    n_checks++;
    if (q_idx.size() != 52) begin n_fail++; $display("FAIL zero_count got=%0d want=52", q_idx.size()); end
    bad = 0;
    for (int j = 0; j < q_idx.size() && j < 52; j++)
      if (q_idx[j] !== j || q_word[j] !== exp_w[j]) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL zero_stream got %0d bad words want 0", bad); end
    if (q_idx.size() > 6) begin
      n_checks++;
      if (q_word[6] !== 32'h62636363) begin n_fail++; $display("FAIL zero_w6 got=%h want=62636363", q_word[6]); end
    end
  endtask

  task automatic test_restart_ignored();
    int bad;
    build_model(KEY_A2);
    run_stream(KEY_A2, 40, KEY_ALT, 0, 100);
    n_checks++;
    if (q_idx.size() != 52) begin n_fail++; $display("FAIL restart_count got=%0d want=52", q_idx.size()); end
    bad = 0;
    for (int j = 0; j < q_idx.size() && j < 52; j++)
      if (q_idx[j] !== j || q_word[j] !== exp_w[j] || q_cyc[j] !== f_cyc(j)) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL restart_stream got %0d bad words want 0", bad); end
    n_checks++;
    if (done_cyc !== 93 || done_cnt !== 1) begin n_fail++; $display("FAIL restart_done got cyc=%0d cnt=%0d want cyc=93 cnt=1", done_cyc, done_cnt); end
  endtask

  task automatic test_reset_midrun();
    int bad;
    build_model(KEY_A2);
    run_stream(KEY_A2, 0, '0, 50, 70);
    n_checks++;
    if (q_idx.size() != 30) begin n_fail++; $display("FAIL midreset_count got=%0d want=30", q_idx.size()); end
    bad = 0;
    for (int j = 0; j < q_idx.size() && j < 30; j++)
      if (q_idx[j] !== j || q_word[j] !== exp_w[j] || q_cyc[j] !== f_cyc(j)) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL midreset_prefix got %0d bad words want 0", bad); end
    n_checks++;
    if (snap !== 55'h0) begin n_fail++; $display("FAIL midreset_outputs got=%h want=0", snap); end
    bad = 0;
    for (int n = 51; n <= 70; n++) if (busy_tr[n] !== 1'b0) bad++;
    n_checks++;
    if (bad != 0 || done_cnt != 0) begin n_fail++; $display("FAIL midreset_idle got busy=%0d done=%0d want 0 0", bad, done_cnt); end
    build_model(KEY_C2);
    run_stream(KEY_C2, 0, '0, 0, 100);
    n_checks++;
    if (q_idx.size() != 52) begin n_fail++; $display("FAIL rerun_count got=%0d want=52", q_idx.size()); end
    bad = 0;
    for (int j = 0; j < q_idx.size() && j < 52; j++)
      if (q_idx[j] !== j || q_word[j] !== exp_w[j] || q_cyc[j] !== f_cyc(j)) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL rerun_stream got %0d bad words want 0", bad); end
    n_checks++;
    if (done_cyc !== 93) begin n_fail++; $display("FAIL rerun_done got=%0d want=93", done_cyc); end
  endtask

  task automatic test_start_during_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b1; key_in = KEY_A2;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      n_checks++;
      if (f_outs() !== 55'h0) begin n_fail++; $display("FAIL held_reset[%0d] got=%h want=0", n, f_outs()); end
    end
    reset = 1'b0; start = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      n_checks++;
      if ({rk_valid, busy, done} !== 3'b000) begin n_fail++; $display("FAIL held_release[%0d] got=%b want=000", n, {rk_valid, busy, done}); end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; key_in = '0;
    test_reset();
    test_fips_stream();
    test_rom_addresses();
    test_zero_key();
    test_restart_ignored();
    test_reset_midrun();
    test_start_during_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
